mem_stage_dcache: RTL and testbench
===================================

// Module: mem_stage_dcache
// PURPOSE
//  MEM-stage data cache: direct-mapped, write-back, write-allocate, 1-cycle hit.
//  Serves pipeline loads/stores from EX/MEM; read word feeds MEM/WB memReadData_i.
//  On a miss it raises p1_stall_o (drives pipeline stall_i) and runs a line refill
//  (plus dirty-victim writeback) against off-chip data memory via an enable/ack handshake.
// PARAMETERS
//  NUM_SETS    32   cache lines; power of 2; index = addr[4+log2(NUM_SETS):5]
//  LINE_BITS   256  line width (32 B, 8 words); offset = addr[4:2], addr[1:0] ignored
// PORTS
//  clk_i          in   1    clock, rising edge
//  rst_i          in   1    asynchronous, active-high reset
//  p1_MemRead_i   in   1    load request this cycle
//  p1_MemWrite_i  in   1    store request this cycle (never both with MemRead)
//  p1_addr_i      in   32   byte address, word aligned
//  p1_data_i      in   32   store data
//  p1_data_o      out  32   load data; valid when request && !p1_stall_o
//  p1_stall_o     out  1    pipeline must hold all stage registers
//  mem_enable_o   out  1    off-chip request, held until mem_ack_i
//  mem_write_o    out  1    1 = write line, 0 = read line
//  mem_addr_o     out  32   line address, [4:0] = 0
//  mem_data_o     out  256  victim line for writeback
//  mem_data_i     in   256  refill line, valid in mem_ack_i cycle
//  mem_ack_i      in   1    one-cycle completion pulse
// BEHAVIOUR
//  req = MemRead|MemWrite; hit = valid[idx] && tag[idx]==addr[31:10] (NUM_SETS=32).
//  Hit (combinational): p1_data_o = word[offset] same cycle; p1_stall_o = req && !hit || state!=IDLE.
//  Store hit: word[offset] <= p1_data_i and dirty[idx] <= 1 at the clock edge with stall low.
//  No request: p1_stall_o = 0, FSM stays IDLE, no array writes.
//  FSM states: IDLE, WRITEBACK, REFILL, REFILL_DONE.
//   IDLE:   req && !hit && valid && dirty -> WRITEBACK; req && !hit otherwise -> REFILL.
//   WRITEBACK: enable=1, write=1, addr={victim tag,idx,5'b0}, data=victim line;
//              on mem_ack_i -> REFILL.
//   REFILL: enable=1, write=0, addr={req tag,idx,5'b0}; on mem_ack_i write line,
//           tag, valid=1, dirty=0 -> REFILL_DONE.
//   REFILL_DONE: 1 cycle, enable=0 -> IDLE; request now hits, store merges then.
//  mem_enable_o deasserts the cycle after mem_ack_i; request fields stable while enabled.
//  Miss latency = mem latency (+ writeback) + 2 cycles; stall stays high throughout.
//  Ack in IDLE/REFILL_DONE ignored. Pipeline holds addr/data stable while stalled.
//  Reset (any time, incl. mid-refill): state=IDLE, all valid/dirty=0, mem_enable_o=0,
//   mem_write_o=0, mem_addr_o=0, mem_data_o=0, p1_data_o=0, p1_stall_o=0 (no request).
//   Outstanding memory transaction is abandoned; its later ack is ignored.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds outputs stat_hit_o[31:0], stat_miss_o[31:0];
//   hit count ++ on each accepted request that hit in IDLE without prior miss,
//   miss count ++ on each IDLE->WRITEBACK/REFILL; both reset to 0, wrap at 2^32.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Shared package/defines file dcache_pkg: FSM state encodings, TAG_W/IDX_W/OFS_W,
//   LINE_BITS, word-select constants.
//  Sub-module dcache_sram: tag/valid/dirty + data arrays, 1-cycle write, async read.
//  Top holds FSM, hit compare, word mux/merge, memory handshake.
// TESTING
//  Reset then load 0x0000_0040 -> stall, REFILL addr 0x40 write=0; ack with line
//   word0=0xDEAD_BEEF -> stall drops after REFILL_DONE, p1_data_o=0xDEAD_BEEF.
//  Store 0x1234_5678 to 0x44 after refill -> no stall; next load 0x44 returns 0x1234_5678.
//  Load 0x0000_0444 (same idx, new tag) after dirty store -> WRITEBACK addr 0x40 with
//   word1=0x1234_5678, then REFILL addr 0x440; stall high until REFILL_DONE exits.
//  Delay ack 10 cycles -> mem_enable_o and mem_addr_o stable all 10 cycles, stall held.
//  Assert rst_i mid-REFILL -> next cycle enable=0, IDLE; late ack ignored; reload misses.
//  DCACHE_STATS_EN: 1 miss + 3 hits -> stat_miss_o=1, stat_hit_o=3.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the MEM-stage data cache: FSM encoding, address field widths, word select.
`timescale 1ns/1ps
package dcache_pkg;

   localparam int DC_NUM_SETS = 32;
   localparam int LINE_BITS   = 256;
   localparam int WORD_W      = 32;
   localparam int WORDS       = LINE_BITS / WORD_W;
   localparam int OFS_W       = $clog2(WORDS);
   localparam int OFS_LSB     = 2;
   localparam int IDX_LSB     = OFS_LSB + OFS_W;
   localparam int IDX_W       = $clog2(DC_NUM_SETS);
   localparam int TAG_W       = 32 - IDX_LSB - IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_WRITEBACK   = 2'd1,
      ST_REFILL      = 2'd2,
      ST_REFILL_DONE = 2'd3
   } state_t;

   function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_BITS-1:0] line,
                                                   input logic [OFS_W-1:0]     ofs);
      return line[ofs*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Cache arrays: valid/dirty bits (reset to 0), tag and line storage; async read, writes at the clock edge.
`timescale 1ns/1ps
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int NUM_SETS = DC_NUM_SETS,
   parameter int IDX_BITS = $clog2(NUM_SETS),
   parameter int TAG_BITS = 32 - IDX_LSB - IDX_BITS
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IDX_BITS-1:0]  idx_i,
   output logic                 valid_o,
   output logic                 dirty_o,
   output logic [TAG_BITS-1:0]  tag_o,
   output logic [LINE_BITS-1:0] line_o,
   input  logic                 fill_i,
   input  logic [TAG_BITS-1:0]  fill_tag_i,
   input  logic [LINE_BITS-1:0] fill_line_i,
   input  logic                 store_i,
   input  logic [OFS_W-1:0]     store_ofs_i,
   input  logic [WORD_W-1:0]    store_dat_i
);

   logic [NUM_SETS-1:0]  valid_q;
   logic [NUM_SETS-1:0]  dirty_q;
   logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
   logic [LINE_BITS-1:0] data_q [NUM_SETS];

   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign line_o  = data_q[idx_i];

   // Only the status bits need reset; tag/data are qualified by valid.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_i) begin
         valid_q[idx_i] <= 1'b1;
         dirty_q[idx_i] <= 1'b0;
      end else if (store_i) begin
         dirty_q[idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill_i) begin
         tag_q[idx_i]  <= fill_tag_i;
         data_q[idx_i] <= fill_line_i;
      end else if (store_i) begin
         data_q[idx_i][store_ofs_i*WORD_W +: WORD_W] <= store_dat_i;
      end
   end

endmodule

// File: rtl/mem_stage_dcache.sv
// MEM-stage direct-mapped write-back/write-allocate D-cache: hits answer in the same cycle, misses stall
// through optional victim writeback plus refill, then 2 cycles. `define DCACHE_STATS_EN adds hit/miss counters.
`timescale 1ns/1ps
module mem_stage_dcache
   import dcache_pkg::*;
#(
   parameter int NUM_SETS = DC_NUM_SETS
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 p1_MemRead_i,
   input  logic                 p1_MemWrite_i,
   input  logic [31:0]          p1_addr_i,
   input  logic [31:0]          p1_data_i,
   output logic [31:0]          p1_data_o,
   output logic                 p1_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]          stat_hit_o,
   output logic [31:0]          stat_miss_o
`endif
);

   localparam int IDX_BITS = $clog2(NUM_SETS);
   localparam int TAG_BITS = 32 - IDX_LSB - IDX_BITS;

   state_t                state_q;
   logic                  mem_enable_q;
   logic                  mem_write_q;
   logic [31:0]           mem_addr_q;
   logic [LINE_BITS-1:0]  mem_data_q;

   logic                  req;
   logic                  hit;
   logic                  miss;
   logic [IDX_BITS-1:0]   idx;
   logic [TAG_BITS-1:0]   req_tag;
   logic [OFS_W-1:0]      ofs;
   logic                  rd_valid;
   logic                  rd_dirty;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [LINE_BITS-1:0]  rd_line;
   logic                  fill;
   logic                  store;
   logic [31:0]           fill_addr;
   logic [31:0]           victim_addr;
   logic                  unused_addr_bits;

   assign req     = p1_MemRead_i | p1_MemWrite_i;
   assign idx     = p1_addr_i[IDX_LSB +: IDX_BITS];
   assign req_tag = p1_addr_i[31 -: TAG_BITS];
   assign ofs     = p1_addr_i[OFS_LSB +: OFS_W];
   assign unused_addr_bits = ^p1_addr_i[OFS_LSB-1:0];

   assign hit  = rd_valid && (rd_tag == req_tag);
   assign miss = req && !hit;

   assign fill  = (state_q == ST_REFILL) && mem_ack_i;
   assign store = (state_q == ST_IDLE) && p1_MemWrite_i && hit;

   assign fill_addr   = {req_tag, idx, {IDX_LSB{1'b0}}};
   assign victim_addr = {rd_tag,  idx, {IDX_LSB{1'b0}}};

   assign p1_stall_o   = miss || (state_q != ST_IDLE);
   assign p1_data_o    = (req && hit) ? word_sel(rd_line, ofs) : '0;
   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

   dcache_sram #(
      .NUM_SETS (NUM_SETS),
      .IDX_BITS (IDX_BITS),
      .TAG_BITS (TAG_BITS)
   ) u_sram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .idx_i       (idx),
      .valid_o     (rd_valid),
      .dirty_o     (rd_dirty),
      .tag_o       (rd_tag),
      .line_o      (rd_line),
      .fill_i      (fill),
      .fill_tag_i  (req_tag),
      .fill_line_i (mem_data_i),
      .store_i     (store),
      .store_ofs_i (ofs),
      .store_dat_i (p1_data_i)
   );

   // Enable stays high across WRITEBACK->REFILL; the address/write flag switch to the refill request.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (miss) begin
                  mem_enable_q <= 1'b1;
                  if (rd_valid && rd_dirty) begin
                     state_q     <= ST_WRITEBACK;
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= victim_addr;
                     mem_data_q  <= rd_line;
                  end else begin
                     state_q     <= ST_REFILL;
                     mem_write_q <= 1'b0;
                     mem_addr_q  <= fill_addr;
                  end
               end
            end
            ST_WRITEBACK: begin
               if (mem_ack_i) begin
                  state_q     <= ST_REFILL;
                  mem_write_q <= 1'b0;
                  mem_addr_q  <= fill_addr;
               end
            end
            ST_REFILL: begin
               if (mem_ack_i) begin
                  state_q      <= ST_REFILL_DONE;
                  mem_enable_q <= 1'b0;
               end
            end
            ST_REFILL_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q      <= ST_IDLE;
               mem_enable_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] hit_cnt_d;
   logic [31:0] miss_cnt_q;
   logic [31:0] miss_cnt_d;
   logic        miss_pend_q;
   logic        miss_pend_d;

   // The request that missed is accepted later as a hit; miss_pend keeps it out of the hit count.
   always_comb begin
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      miss_pend_d = miss_pend_q;
      if ((state_q == ST_IDLE) && req) begin
         if (hit) begin
            if (miss_pend_q) begin
               miss_pend_d = 1'b0;
            end else begin
               hit_cnt_d = hit_cnt_q + 32'd1;
            end
         end else begin
            miss_cnt_d  = miss_cnt_q + 32'd1;
            miss_pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         miss_pend_q <= 1'b0;
      end else begin
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         miss_pend_q <= miss_pend_d;
      end
   end

   assign stat_hit_o  = hit_cnt_q;
   assign stat_miss_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Bench for mem_stage_dcache: directed scenarios then random loads/stores against a flat-memory reference.
`timescale 1ns/1ps
module tb_mem_stage_dcache;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         p1_MemRead_i = 1'b0;
   logic         p1_MemWrite_i = 1'b0;
   logic [31:0]  p1_addr_i = '0;
   logic [31:0]  p1_data_i = '0;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
   logic [31:0]  stat_hit_o;
   logic [31:0]  stat_miss_o;
`endif

   always #5 clk_i = ~clk_i;

   mem_stage_dcache dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .p1_MemRead_i  (p1_MemRead_i),
      .p1_MemWrite_i (p1_MemWrite_i),
      .p1_addr_i     (p1_addr_i),
      .p1_data_i     (p1_data_i),
      .p1_data_o     (p1_data_o),
      .p1_stall_o    (p1_stall_o),
      .mem_enable_o  (mem_enable_o),
      .mem_write_o   (mem_write_o),
      .mem_addr_o    (mem_addr_o),
      .mem_data_o    (mem_data_o),
      .mem_data_i    (mem_data_i),
      .mem_ack_i     (mem_ack_i)
`ifdef DCACHE_STATS_EN
      ,
      .stat_hit_o    (stat_hit_o),
      .stat_miss_o   (stat_miss_o)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: backing memory (line granular) plus architectural word values seen by the pipeline.
   logic [255:0] backing [logic [31:0]];
   logic [31:0]  golden  [logic [31:0]];
   bit           m_valid [32];
   bit           m_dirty [32];
   logic [21:0]  m_tag   [32];
   int           m_hits;
   int           m_misses;

   logic [32:0]  obs_q [$];
   int           mem_delay = 1;
   bit           resp_en = 1'b1;
   bit           late_ack = 1'b0;
   logic [255:0] last_wb = '0;
   logic [31:0]  last_wb_addr = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   function automatic logic [255:0] line_of(input logic [31:0] la);
      logic [255:0] l;
      if (backing.exists(la)) return backing[la];
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i*4));
      return l;
   endfunction

   function automatic logic [31:0] golden_word(input logic [31:0] a);
      logic [255:0] l;
      if (golden.exists(a)) return golden[a];
      l = line_of({a[31:5], 5'b0});
      return l[a[4:2]*32 +: 32];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
      end
      golden.delete();
      m_hits   = 0;
      m_misses = 0;
   endtask

   // Off-chip memory: acks mem_delay cycles after enable is seen, one-cycle ack pulse.
   initial begin : responder
      int          cnt;
      logic [32:0] first;
      bit          unstable;
      cnt = 0;
      first = '0;
      unstable = 1'b0;
      mem_ack_i = 1'b0;
      mem_data_i = '0;
      forever begin
         @(negedge clk_i);
         if (!resp_en) begin
            cnt = 0;
            mem_ack_i = late_ack;
            for (int i = 0; i < 8; i++) mem_data_i[i*32 +: 32] = $urandom;
         end else if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            cnt = 0;
         end else if (mem_enable_o) begin
            cnt++;
            if (cnt == 1) begin
               first = {mem_write_o, mem_addr_o};
               obs_q.push_back(first);
               unstable = 1'b0;
            end else if ({mem_write_o, mem_addr_o} !== first) begin
               unstable = 1'b1;
            end
            if (cnt >= mem_delay) begin
               check("mem_req_stable", 64'(unstable), 64'd0);
               if (mem_write_o) begin
                  for (int i = 0; i < 8; i++)
                     check("wb_word", 64'(mem_data_o[i*32 +: 32]),
                           64'(golden_word(mem_addr_o + 32'(i*4))));
                  backing[mem_addr_o] = mem_data_o;
                  last_wb = mem_data_o;
                  last_wb_addr = mem_addr_o;
               end else begin
                  mem_data_i = line_of(mem_addr_o);
               end
               mem_ack_i = 1'b1;
            end
         end
      end
   end

   // One pipeline access: drive, wait out the stall, check against the reference, accept at the edge.
   task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdat,
                         input int d, output logic [31:0] rdat);
      int          idx;
      logic [21:0] tg;
      bit          exp_miss;
      bit          exp_wb;
      int          stalled;
      int          exp_stall;
      logic [32:0] expq [$];
      idx = int'(addr[9:5]);
      tg  = addr[31:10];
      exp_miss = !(m_valid[idx] && m_tag[idx] == tg);
      exp_wb   = exp_miss && m_valid[idx] && m_dirty[idx];
      if (exp_wb)   expq.push_back({1'b1, m_tag[idx], 5'(idx), 5'b0});
      if (exp_miss) expq.push_back({1'b0, tg, 5'(idx), 5'b0});
      exp_stall = !exp_miss ? 0 : (exp_wb ? 2*d + 3 : d + 2);
      mem_delay = d;
      obs_q.delete();
      p1_MemRead_i  = !wr;
      p1_MemWrite_i = wr;
      p1_addr_i     = addr;
      p1_data_i     = wdat;
      stalled = 0;
      @(negedge clk_i);
      while (p1_stall_o && stalled < 200) begin
         stalled++;
         @(negedge clk_i);
      end
      if (p1_stall_o) check("stall_timeout", 64'd1, 64'd0);
      check("stall_cycles", 64'(stalled), 64'(exp_stall));
      rdat = p1_data_o;
      if (!wr) check("load_data", 64'(p1_data_o), 64'(golden_word(addr)));
      check("mem_txn_count", 64'(obs_q.size()), 64'(expq.size()));
      for (int i = 0; i < expq.size() && i < obs_q.size(); i++)
         check("mem_txn", 64'(obs_q[i]), 64'(expq[i]));
      if (exp_miss) begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
         m_dirty[idx] = 1'b0;
         m_misses++;
      end else begin
         m_hits++;
      end
      if (wr) begin
         m_dirty[idx] = 1'b1;
         golden[addr] = wdat;
      end
      @(posedge clk_i);
      #1;
`ifdef DCACHE_STATS_EN
      check("stat_hit", 64'(stat_hit_o), 64'(m_hits));
      check("stat_miss", 64'(stat_miss_o), 64'(m_misses));
`endif
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench did not finish");
   end

   initial begin : main
      logic [31:0]  rd;
      logic [255:0] l;
      logic [31:0]  a;
      model_reset();
      repeat (2) @(negedge clk_i);
      check("rst_stall", 64'(p1_stall_o), 64'd0);
      check("rst_enable", 64'(mem_enable_o), 64'd0);
      check("rst_write", 64'(mem_write_o), 64'd0);
      check("rst_addr", 64'(mem_addr_o), 64'd0);
      check("rst_rdata", 64'(p1_data_o), 64'd0);
      check("rst_wbdata", 64'(mem_data_o[63:0]), 64'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      l = line_of(32'h40);
      l[31:0] = 32'hDEAD_BEEF;
      backing[32'h40] = l;
      access(1'b0, 32'h0000_0040, 32'h0, 1, rd);
      check("first_load", 64'(rd), 64'h0000_0000_DEAD_BEEF);
      access(1'b1, 32'h0000_0044, 32'h1234_5678, 1, rd);
      access(1'b0, 32'h0000_0044, 32'h0, 1, rd);
      check("store_readback", 64'(rd), 64'h0000_0000_1234_5678);
      access(1'b0, 32'h0000_0444, 32'h0, 2, rd);
      check("victim_addr", 64'(last_wb_addr), 64'h40);
      check("victim_word1", 64'(last_wb[63:32]), 64'h0000_0000_1234_5678);
      access(1'b0, 32'h0000_1000, 32'h0, 10, rd);

      // Reset in the middle of a refill; the late ack must be ignored.
      mem_delay = 1000;
      p1_MemWrite_i = 1'b0;
      p1_MemRead_i  = 1'b1;
      p1_addr_i     = 32'h0000_2000;
      repeat (3) @(negedge clk_i);
      check("mid_refill_enable", 64'(mem_enable_o), 64'd1);
      check("mid_refill_stall", 64'(p1_stall_o), 64'd1);
      @(posedge clk_i);
      #1;
      p1_MemRead_i = 1'b0;
      resp_en = 1'b0;
      rst_i = 1'b1;
      #1;
      check("arst_enable", 64'(mem_enable_o), 64'd0);
      check("arst_stall", 64'(p1_stall_o), 64'd0);
      check("arst_addr", 64'(mem_addr_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      late_ack = 1'b1;
      @(posedge clk_i);
      #1;
      late_ack = 1'b0;
      check("late_ack_enable", 64'(mem_enable_o), 64'd0);
      check("late_ack_stall", 64'(p1_stall_o), 64'd0);
      @(negedge clk_i);
      resp_en = 1'b1;
      model_reset();
      @(posedge clk_i);
      #1;
      access(1'b0, 32'h0000_2000, 32'h0, 2, rd);
      access(1'b0, 32'h0000_0044, 32'h0, 1, rd);
      check("wb_survives_reset", 64'(rd), 64'h0000_0000_1234_5678);
      access(1'b0, 32'h0000_0048, 32'h0, 1, rd);
      access(1'b0, 32'h0000_004C, 32'h0, 1, rd);

      for (int n = 0; n < 250; n++) begin
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
           | (32'($urandom_range(0, 7)) << 2);
         access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 3), rd);
      end

      p1_MemRead_i  = 1'b0;
      p1_MemWrite_i = 1'b0;
      @(negedge clk_i);
      check("idle_stall", 64'(p1_stall_o), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
